tt_um_load_ctrl: RTL and testbench

// - Sequencer that fills the ternary weight latch array from an 8-bit byte stream on TT dedicated inputs.
// - Assembles MAX_IN_LEN-bit column words, then drives the column select, data and enable of the

---
 rtl/tt_um_load_ctrl.sv | 141 ++++++++++++++
 tb/tb_tt_um_load_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_load_ctrl.sv
// rtl/tt_um_load_ctrl.sv - byte-stream sequencer for the latch weight loader; LOAD_CHECKSUM_EN adds a trailing checksum byte
module tt_um_load_ctrl #(
   parameter int MAX_IN_LEN  = 16,
   parameter int MAX_OUT_LEN = 8,
   parameter int WIDTH       = 2,
   parameter int COL_BITS    = $clog2(MAX_OUT_LEN*WIDTH),
   parameter int BYTES       = MAX_IN_LEN/8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  load_ena,
   output logic [COL_BITS-1:0]   load_col,
   output logic [MAX_IN_LEN-1:0] load_data,
   output logic                  busy,
   output logic                  done,
   output logic                  chk_err
);
   localparam int BC_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [COL_BITS-1:0] LAST_COL  = COL_BITS'(MAX_OUT_LEN*WIDTH-1);
   localparam logic [BC_BITS-1:0]  LAST_BYTE = BC_BITS'(BYTES-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_SETUP,
      S_STROBE,
      S_HOLD
`ifdef LOAD_CHECKSUM_EN
      , S_CHECK
`endif
   } state_t;

   state_t             state;
   logic [BC_BITS-1:0] byte_cnt;
   logic               hs;

   assign hs = in_valid & in_ready;

`ifdef LOAD_CHECKSUM_EN
   logic [7:0] xor_acc;
   logic       chk_err_q;
   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

   // SETUP/STROBE/HOLD bracket each enable pulse so the open latches see stable column and data
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         byte_cnt  <= '0;
         in_ready  <= 1'b0;
         load_ena  <= 1'b0;
         load_col  <= '0;
         load_data <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
         xor_acc   <= '0;
         chk_err_q <= 1'b0;
`endif
      end else if (abort) begin
         state    <= S_IDLE;
         in_ready <= 1'b0;
         load_ena <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_RECV;
                  load_col  <= '0;
                  byte_cnt  <= '0;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  in_ready  <= 1'b1;
`ifdef LOAD_CHECKSUM_EN
                  xor_acc   <= '0;
                  chk_err_q <= 1'b0;
`endif
               end
            end
            S_RECV: begin
               if (hs) begin
                  load_data[8*int'(byte_cnt) +: 8] <= in_byte;
                  byte_cnt <= byte_cnt + BC_BITS'(1);
`ifdef LOAD_CHECKSUM_EN
                  xor_acc  <= xor_acc ^ in_byte;
`endif
                  if (byte_cnt == LAST_BYTE) begin
                     state    <= S_SETUP;
                     in_ready <= 1'b0;
                  end
               end
            end
            S_SETUP: begin
               state    <= S_STROBE;
               load_ena <= 1'b1;
            end
            S_STROBE: begin
               state    <= S_HOLD;
               load_ena <= 1'b0;
            end
            S_HOLD: begin
               if (load_col == LAST_COL) begin
`ifdef LOAD_CHECKSUM_EN
                  state    <= S_CHECK;
                  in_ready <= 1'b1;
`else
                  state    <= S_IDLE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
`endif
               end else begin
                  load_col <= load_col + COL_BITS'(1);
                  byte_cnt <= '0;
                  state    <= S_RECV;
                  in_ready <= 1'b1;
               end
            end
`ifdef LOAD_CHECKSUM_EN
            S_CHECK: begin
               if (hs) begin
                  chk_err_q <= (in_byte != xor_acc);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  in_ready  <= 1'b0;
                  state     <= S_IDLE;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tt_um_load_ctrl.sv
// tb/tb_tt_um_load_ctrl.sv - directed bench for tt_um_load_ctrl with a strobe scoreboard
module tb_tt_um_load_ctrl;
   localparam int NCOL = 16;
`ifdef LOAD_CHECKSUM_EN
   localparam int NBYTES   = 33;
   localparam int LOAD_CYC = 81;
`else
   localparam int NBYTES   = 32;
   localparam int LOAD_CYC = 80;
`endif

   logic        clk = 1'b0;
   logic        rst, start, abort, in_valid;
   logic [7:0]  in_byte;
   logic        in_ready, load_ena, busy, done, chk_err;
   logic [3:0]  load_col;
   logic [15:0] load_data;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc, nb;

   typedef struct packed {
      logic [3:0]  col;
      logic [15:0] data;
   } strobe_t;
   strobe_t exp_q[$];

   always #5 clk = ~clk;

   tt_um_load_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .load_ena(load_ena), .load_col(load_col), .load_data(load_data),
      .busy(busy), .done(done), .chk_err(chk_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Each enable pulse must match the next expected column and last exactly one cycle
   initial begin
      strobe_t     e;
      logic [3:0]  c;
      logic [15:0] d;
      forever begin
         @(negedge clk);
         if (load_ena === 1'b1) begin
            c = load_col;
            d = load_data;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {28'd0, c}, 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("strobe_col", {28'd0, c}, {28'd0, e.col});
               check("strobe_data", {16'd0, d}, {16'd0, e.data});
            end
            @(negedge clk);
            check("ena_one_cycle", {31'd0, load_ena}, 32'd0);
            check("col_hold", {28'd0, load_col}, {28'd0, c});
            check("data_hold", {16'd0, load_data}, {16'd0, d});
         end
      end
   end

   task automatic run_load(input bit toggle, input int abort_col, input int busy_start_col,
                           input logic [7:0] chk_byte, output int cycles, output int taken);
      logic [7:0] stream [0:32];
      int  idx;
      bit  hs, v, aborted;
      for (int i = 0; i < 32; i++) stream[i] = 8'(i);
      stream[32] = chk_byte;
      for (int c = 0; c < NCOL; c++)
         if (abort_col < 0 || c <= abort_col)
            exp_q.push_back({4'(c), 8'(2*c+1), 8'(2*c)});
      idx = 0;
      cycles = 0;
      aborted = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         start = 1'b0;
         if (done || cycles > 400) break;
         if (abort_col >= 0 && load_ena && load_col == 4'(abort_col)) begin
            abort    = 1'b1;
            in_valid = 1'b0;
            hs       = 1'b0;
         end else begin
            v        = (!toggle || cycles[0]) && idx < NBYTES;
            in_valid = v;
            in_byte  = stream[(idx < NBYTES) ? idx : 0];
            hs       = v && in_ready;
            if (busy_start_col >= 0 && load_col == 4'(busy_start_col)) start = 1'b1;
         end
         @(posedge clk);
         cycles++;
         if (hs) idx++;
         if (abort) begin
            aborted = 1;
            break;
         end
      end
      in_valid = 1'b0;
      if (cycles > 400) check("timeout", 32'(cycles), 32'd400);
      if (aborted) begin
         @(negedge clk);
         abort = 1'b0;
         check("abort_ena", {31'd0, load_ena}, 32'd0);
         check("abort_busy", {31'd0, busy}, 32'd0);
         check("abort_done", {31'd0, done}, 32'd0);
         check("abort_ready", {31'd0, in_ready}, 32'd0);
      end
      taken = idx;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_load_ena", {31'd0, load_ena}, 32'd0);
      check("rst_load_col", {28'd0, load_col}, 32'd0);
      check("rst_load_data", {16'd0, load_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_chk_err", {31'd0, chk_err}, 32'd0);

      run_load(0, -1, -1, 8'h00, cyc, nb);
      check("b2b_cycles", 32'(cyc), 32'(LOAD_CYC));
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_busy", {31'd0, busy}, 32'd0);
      check("b2b_ready", {31'd0, in_ready}, 32'd0);
      check("b2b_bytes", 32'(nb), 32'(NBYTES));
      check("b2b_chk_err", {31'd0, chk_err}, 32'd0);
      check("b2b_last_col", {28'd0, load_col}, 32'd15);
      check("b2b_last_data", {16'd0, load_data}, 32'h1f1e);
      check("b2b_queue", 32'(exp_q.size()), 32'd0);

      run_load(1, -1, -1, 8'h00, cyc, nb);
      check("toggle_done", {31'd0, done}, 32'd1);
      check("toggle_bytes", 32'(nb), 32'(NBYTES));
      check("toggle_queue", 32'(exp_q.size()), 32'd0);

      run_load(0, 5, -1, 8'h00, cyc, nb);
      check("abort_queue", 32'(exp_q.size()), 32'd0);
      check("abort_col", {28'd0, load_col}, 32'd5);
      repeat (3) @(negedge clk);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      run_load(0, -1, 3, 8'h00, cyc, nb);
      check("restart_cycles", 32'(cyc), 32'(LOAD_CYC));
      check("restart_done", {31'd0, done}, 32'd1);
      check("restart_bytes", 32'(nb), 32'(NBYTES));
      check("restart_queue", 32'(exp_q.size()), 32'd0);
      check("restart_chk_err", {31'd0, chk_err}, 32'd0);

`ifdef LOAD_CHECKSUM_EN
      run_load(0, -1, -1, 8'h01, cyc, nb);
      check("bad_sum_done", {31'd0, done}, 32'd1);
      check("bad_sum_chk_err", {31'd0, chk_err}, 32'd1);
      check("bad_sum_queue", 32'(exp_q.size()), 32'd0);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
